// File: rtl/stp_pkg.sv
// Shared types and sizing helpers for the serial-to-parallel converter.
package stp_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bit counter must be able to hold the value WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_to_parallel_converter_sipo_shift_reg.sv
// Serial-in shift register; word_next is the value the register takes on the
// coming edge so the top can capture a completed word on that same edge.
module sipo_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en,
    input  logic             clear,
    input  logic             serial_in,
    output logic [WIDTH-1:0] word_next
);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] base;

    // clear together with shift_en restarts the word with serial_in as bit 0
    always_comb begin
        base      = clear ? '0 : q;
        word_next = base;
        if (shift_en) begin
            word_next = MSB_FIRST ? {base[WIDTH-2:0], serial_in}
                                  : {serial_in, base[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= word_next;
        end
    end

endmodule

// File: rtl/serial_to_parallel_converter.sv
// Deserialiser: assembles strobed serial bits into WIDTH-bit words and holds
// them in a one-entry valid/ready output register.
module serial_to_parallel_converter
    import stp_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             SerialIn,
    input  logic             BitValid,
    input  logic             FrameStart,
    output logic [WIDTH-1:0] ParallelOut,
    output logic             ParallelValid,
    input  logic             ParallelReady,
    output logic             FrameError,
    output logic             Overrun,
    output logic             Busy
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             shift_en, clear, complete, frame_err_n;
    logic [WIDTH-1:0] word_next;

    sipo_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_sipo (
        .clk       (Clk),
        .reset     (Reset),
        .shift_en  (shift_en),
        .clear     (clear),
        .serial_in (SerialIn),
        .word_next (word_next)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        shift_en    = 1'b0;
        clear       = 1'b0;
        complete    = 1'b0;
        frame_err_n = 1'b0;
        case (state)
            IDLE: begin
                if (BitValid && FrameStart) begin
                    shift_en = 1'b1;
                    clear    = 1'b1;
                    cnt_n    = CNT_ONE;
                    state_n  = SHIFT;
                end
            end
            SHIFT: begin
                if (BitValid) begin
                    shift_en = 1'b1;
                    if (FrameStart) begin
                        clear       = 1'b1;
                        frame_err_n = 1'b1;
                        cnt_n       = CNT_ONE;
                    end else if (cnt == CNT_LAST) begin
                        complete = 1'b1;
                        cnt_n    = '0;
                        state_n  = IDLE;
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // A completed word is accepted when the slot is empty or being drained
    // on this edge; otherwise it is dropped and the held word is kept.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ParallelOut   <= '0;
            ParallelValid <= 1'b0;
            FrameError    <= 1'b0;
            Overrun       <= 1'b0;
        end else begin
            FrameError <= frame_err_n;
            if (complete && (!ParallelValid || ParallelReady)) begin
                ParallelOut   <= word_next;
                ParallelValid <= 1'b1;
            end else begin
                if (complete) begin
                    Overrun <= 1'b1;
                end
                if (ParallelValid && ParallelReady) begin
                    ParallelValid <= 1'b0;
                end
            end
        end
    end

    assign Busy = (state == SHIFT);

endmodule

// File: tb/tb_serial_to_parallel_converter.sv
// Scoreboard bench: MSB-first and LSB-first instances share one stimulus stream.
module tb_serial_to_parallel_converter;

    localparam int W = 8;

    logic         Clk = 1'b0;
    logic         Reset, SerialIn, BitValid, FrameStart, ParallelReady;
    logic [W-1:0] out_m, out_l;
    logic         val_m, val_l, fe_m, fe_l, ov_m, ov_l, busy_m, busy_l;

    int n_cmp = 0;
    int n_bad = 0;
    int fe_cnt_m = 0;
    int fe_cnt_l = 0;
    logic [W-1:0] q_m[$];
    logic [W-1:0] q_l[$];

    always #5 Clk = ~Clk;

    serial_to_parallel_converter #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .Clk(Clk), .Reset(Reset), .SerialIn(SerialIn), .BitValid(BitValid),
        .FrameStart(FrameStart), .ParallelOut(out_m), .ParallelValid(val_m),
        .ParallelReady(ParallelReady), .FrameError(fe_m), .Overrun(ov_m),
        .Busy(busy_m)
    );

    serial_to_parallel_converter #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .Clk(Clk), .Reset(Reset), .SerialIn(SerialIn), .BitValid(BitValid),
        .FrameStart(FrameStart), .ParallelOut(out_l), .ParallelValid(val_l),
        .ParallelReady(ParallelReady), .FrameError(fe_l), .Overrun(ov_l),
        .Busy(busy_l)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops an expected word whenever a transfer happens on the next edge.
    initial begin
        forever begin
            @(negedge Clk);
            if (!Reset) begin
                if (fe_m) fe_cnt_m++;
                if (fe_l) fe_cnt_l++;
                if (val_m && ParallelReady) begin
                    if (q_m.size() == 0) check("msb unexpected word", {24'd0, out_m}, 32'hFFFF_FFFF);
                    else check("msb word", {24'd0, out_m}, {24'd0, q_m.pop_front()});
                end
                if (val_l && ParallelReady) begin
                    if (q_l.size() == 0) check("lsb unexpected word", {24'd0, out_l}, 32'hFFFF_FFFF);
                    else check("lsb word", {24'd0, out_l}, {24'd0, q_l.pop_front()});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic push2(input logic [W-1:0] msb_word, input logic [W-1:0] lsb_word);
        q_m.push_back(msb_word);
        q_l.push_back(lsb_word);
    endtask

    // Bits go out w[7] first; rdy_last raises ParallelReady for the last bit's edge.
    task automatic send_bits(input logic [W-1:0] w, input int nbits, input bit gaps, input bit rdy_last);
        for (int i = 0; i < nbits; i++) begin
            BitValid   = 1'b1;
            SerialIn   = w[W-1-i];
            FrameStart = (i == 0);
            if (rdy_last && i == nbits - 1) ParallelReady = 1'b1;
            @(posedge Clk); #1;
            BitValid   = 1'b0;
            FrameStart = 1'b0;
            if (gaps) begin
                @(posedge Clk); #1;
            end
        end
    endtask

    task automatic tick();
        @(posedge Clk); #1;
    endtask

    int fe0;

    initial begin
        Reset = 1'b1; SerialIn = 1'b0; BitValid = 1'b0; FrameStart = 1'b0; ParallelReady = 1'b0;
        tick(); tick();
        check("reset out", {24'd0, out_m}, 32'h0);
        check("reset valid", {31'd0, val_m}, 32'h0);
        check("reset ferr", {31'd0, fe_m}, 32'h0);
        check("reset overrun", {31'd0, ov_m}, 32'h0);
        check("reset busy", {31'd0, busy_m}, 32'h0);
        Reset = 1'b0;
        tick();

        // Basic MSB-first word with immediate consume
        ParallelReady = 1'b1;
        push2(8'hA5, 8'hA5);
        send_bits(8'hA5, 8, 1'b0, 1'b0);
        check("basic valid after last bit", {31'd0, val_m}, 32'h1);
        check("basic busy after complete", {31'd0, busy_m}, 32'h0);
        tick();
        check("basic valid one cycle", {31'd0, val_m}, 32'h0);

        // Gapped strobes; LSB-first instance sees bit-reversed words
        push2(8'hA5, 8'hA5);
        send_bits(8'hA5, 8, 1'b1, 1'b0);
        push2(8'hC0, 8'h03);
        send_bits(8'hC0, 8, 1'b1, 1'b0);

        // Framing error: restart after 5 bits
        fe0 = fe_cnt_m;
        send_bits(8'hFF, 5, 1'b0, 1'b0);
        check("busy mid-frame", {31'd0, busy_m}, 32'h1);
        check("valid mid-frame", {31'd0, val_m}, 32'h0);
        push2(8'h3C, 8'h3C);
        send_bits(8'h3C, 8, 1'b0, 1'b0);
        tick();
        check("frame error pulses msb", fe_cnt_m - fe0, 32'd1);
        check("frame error pulses lsb", fe_cnt_l - fe0, 32'd1);

        // Backpressure and overrun
        ParallelReady = 1'b0;
        push2(8'h11, 8'h88);
        send_bits(8'h11, 8, 1'b0, 1'b0);
        check("no overrun yet", {31'd0, ov_m}, 32'h0);
        send_bits(8'h22, 8, 1'b0, 1'b0);
        check("held valid", {31'd0, val_m}, 32'h1);
        check("held word msb", {24'd0, out_m}, 32'h11);
        check("held word lsb", {24'd0, out_l}, 32'h88);
        check("overrun msb", {31'd0, ov_m}, 32'h1);
        check("overrun lsb", {31'd0, ov_l}, 32'h1);
        tick(); tick(); tick();
        check("held word stable", {24'd0, out_m}, 32'h11);
        check("held valid stable", {31'd0, val_m}, 32'h1);
        ParallelReady = 1'b1;
        tick();
        check("valid drops after consume", {31'd0, val_m}, 32'h0);
        check("overrun sticky", {31'd0, ov_m}, 32'h1);

        // Completion coincident with consume
        Reset = 1'b1; tick(); Reset = 1'b0;
        check("overrun cleared by reset", {31'd0, ov_m}, 32'h0);
        ParallelReady = 1'b0;
        push2(8'h11, 8'h88);
        send_bits(8'h11, 8, 1'b0, 1'b0);
        push2(8'h22, 8'h44);
        send_bits(8'h22, 8, 1'b0, 1'b1);
        check("coincident valid", {31'd0, val_m}, 32'h1);
        check("coincident word", {24'd0, out_m}, 32'h22);
        check("coincident no overrun", {31'd0, ov_m}, 32'h0);
        tick();
        check("coincident drained", {31'd0, val_m}, 32'h0);

        // Reset mid-frame, then a clean frame
        fe0 = fe_cnt_m;
        send_bits(8'hAB, 4, 1'b0, 1'b0);
        Reset = 1'b1;
        tick();
        check("midreset out", {24'd0, out_m}, 32'h0);
        check("midreset valid", {31'd0, val_m}, 32'h0);
        check("midreset busy", {31'd0, busy_m}, 32'h0);
        check("midreset ferr", {31'd0, fe_m}, 32'h0);
        Reset = 1'b0;
        tick();
        push2(8'hF0, 8'h0F);
        send_bits(8'hF0, 8, 1'b0, 1'b0);
        tick();
        check("no frame error after reset", fe_cnt_m - fe0, 32'd0);

        tick(); tick();
        check("msb queue drained", q_m.size(), 32'd0);
        check("lsb queue drained", q_l.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_to_parallel_converter.md
Name: serial_to_parallel_converter

Overview:
Deserialiser stage directly downstream of the 2:1 serial source select MUX. Takes the selected serial bit stream (MUX Out) with a per-bit strobe and a frame-start marker, and assembles WIDTH-bit words. Presents each completed word on a one-entry valid/ready output register for the parallel consumer. Flags framing errors and overruns.

Parameters:
WIDTH, 8, bits per parallel word (>= 2)
MSB_FIRST, 1, 1 = first received bit lands in ParallelOut[WIDTH-1]; 0 = first bit lands in ParallelOut[0]

Ports:
Clk  input  1  system clock, all logic on rising edge
Reset  input  1  synchronous, active-high reset
SerialIn  input  1  serial data bit (driven by MUX Out)
BitValid  input  1  SerialIn is sampled on this edge only when high
FrameStart  input  1  qualified by BitValid; marks the current bit as bit 0 of a new word
ParallelOut  output  WIDTH  assembled word, stable while ParallelValid is high
ParallelValid  output  1  output register holds an unconsumed word
ParallelReady  input  1  consumer accepts the word when ParallelValid && ParallelReady
FrameError  output  1  one-cycle pulse: partial word discarded by a new FrameStart
Overrun  output  1  sticky: completed word dropped because the output register was full
Busy  output  1  high while the FSM is in SHIFT

Behaviour:
- Reset: synchronous and active-high, sampled on the Clk rising edge. All outputs are 0, FSM is IDLE, bit counter is 0, shift register is 0. Reset overrides every other input on the same edge, including mid-frame; a partial word is discarded with no FrameError.
- The FSM has two states: IDLE and SHIFT.
- IDLE:
  - BitValid && FrameStart: shift in SerialIn, set count=1, go to SHIFT.
  - BitValid without FrameStart: ignore the bit.
  - All other inputs: hold.
- SHIFT:
  - No BitValid: hold state, count and shift register.
  - BitValid && !FrameStart: shift in SerialIn, count increments.
  - BitValid && FrameStart: discard the partial word, pulse FrameError for one cycle, shift the new bit in as bit 0, set count=1, stay in SHIFT.
  - When the accepted bit makes count==WIDTH: the word is complete; go to IDLE with count=0.
- Shift direction:
  - MSB_FIRST=1: shift left, new bit enters at LSB.
  - MSB_FIRST=0: shift right, new bit enters at MSB.
  - In both cases the final word has its first bit at the documented position.
- Completion:
  - The completed word is loaded into the ParallelOut register on the same edge that accepts its last bit.
  - ParallelValid rises one cycle after that edge, so latency from the last bit to the word being visible is 1 clock.
- Output handshake:
  - A transfer occurs on an edge where ParallelValid && ParallelReady.
  - ParallelValid and ParallelOut must not change while ParallelValid is high and ParallelReady is low.
  - ParallelValid falls after the transfer unless a new word loads on the same edge.
- Simultaneous completion and consume: if a word completes on the same edge as a transfer, the new word loads and ParallelValid stays high. No bubble, no overrun.
- Full register: if a word completes while ParallelValid is high and ParallelReady is low, the new word is dropped, the held word is preserved, and Overrun is set to 1. Overrun clears only on Reset.
- Back-to-back frames: a FrameStart on the cycle after completion starts the next word with no dead cycle.
- Bit counter is $clog2(WIDTH+1) bits wide and never exceeds WIDTH.
- Busy = (state==SHIFT).

Decomposition:
- Shared package (stp_pkg):
  - state enum {IDLE, SHIFT}
  - counter width function
  - default WIDTH constant
- One sub-module is natural: sipo_shift_reg (WIDTH, MSB_FIRST; ports Clk, Reset, Load/Shift enable, Clear, SerialIn, Q).
- The FSM, counter and output register stay in the top.

Test Plan:
- Basic word: WIDTH=8, MSB_FIRST=1, send 1,0,1,0,0,1,0,1 (FrameStart on the first bit) with BitValid every cycle, ParallelReady=1 -> ParallelOut=8'hA5, and ParallelValid is high for exactly 1 cycle, starting 1 clock after the 8th bit.
- LSB-first with gaps: MSB_FIRST=0, same bit sequence with BitValid toggling 1,0 -> ParallelOut=8'hA5 bit-reversed = 8'hA5 (palindrome check). Then send 1,1,0,0,0,0,0,0 -> ParallelOut=8'h03.
- Framing error: after 5 bits, assert FrameStart with a new 8-bit frame 8'h3C -> FrameError pulses for 1 cycle, and ParallelOut=8'h3C.
- Backpressure/overrun: hold ParallelReady=0 and send 8'h11 then 8'h22 -> ParallelOut stays 8'h11 with ParallelValid=1, and Overrun=1 after 8'h22 completes. Then release ParallelReady -> ParallelValid drops and Overrun stays 1.
- Completion coincident with consume: word 8'h11 pending; raise ParallelReady on the same edge 8'h22 completes -> ParallelOut=8'h22, ParallelValid stays 1, Overrun=0.
- Reset mid-frame: assert Reset after 4 bits -> all outputs 0 and no FrameError. A following full frame 8'hF0 -> ParallelOut=8'hF0.
